// File: rtl/jtopl_eg_pkg.sv
// Shared definitions for the OPL envelope control stage: ADSR encoding,
// rate width and the four step patterns selected by rate[1:0].
package jtopl_eg_pkg;

  localparam int RATE_W = 6;

  typedef enum logic [1:0] {
    EG_ATTACK  = 2'd0,
    EG_DECAY   = 2'd1,
    EG_SUSTAIN = 2'd2,
    EG_RELEASE = 2'd3
  } eg_state_t;

  // Bit n of each pattern is the step for counter phase n.
  localparam logic [7:0] STEP_P0 = 8'b0101_0101;
  localparam logic [7:0] STEP_P1 = 8'b0101_0111;
  localparam logic [7:0] STEP_P2 = 8'b0111_0111;
  localparam logic [7:0] STEP_P3 = 8'b0111_1111;

  function automatic logic step_bit(input logic [1:0] sel, input logic [2:0] idx);
    logic [7:0] pat;
    case (sel)
      2'd0:    pat = STEP_P0;
      2'd1:    pat = STEP_P1;
      2'd2:    pat = STEP_P2;
      default: pat = STEP_P3;
    endcase
    return pat[idx];
  endfunction

endpackage

// File: rtl/jtopl_eg_ring.sv
// SLOTS-deep shift ring advancing one entry per cen; the head is the entry
// written SLOTS cen cycles earlier. Synchronous active-low clear to RST_VAL.
module jtopl_eg_ring #(
  parameter int          W       = 1,
  parameter int          SLOTS   = 18,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cen,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [SLOTS];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SLOTS; i++) r_mem[i] <= RST_VAL;
    end else if (i_cen) begin
      r_mem[0] <= i_din;
      for (int i = 1; i < SLOTS; i++) r_mem[i] <= r_mem[i-1];
    end
  end

  assign o_head = r_mem[SLOTS-1];

endmodule

// File: rtl/jtopl_eg_ctrl.sv
// Per-slot envelope control: ADSR tracking, effective rate, global counter
// and step lookup. Define JTOPL_EG_FASTATT_EN to skip attack when arate==15.
//
// state   | meaning
// ATTACK  | attenuation falling towards 0 after key-on
// DECAY   | rising towards the sustain level
// SUSTAIN | held at sustain level (sustained envelopes only)
// RELEASE | key released, rising to silence
module jtopl_eg_ctrl
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = 18
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cen,
  input  logic       i_zero,
  input  logic       i_keyon,
  input  logic       i_egtype,
  input  logic       i_ksr,
  input  logic [3:0] i_keycode,
  input  logic [3:0] i_arate,
  input  logic [3:0] i_drate,
  input  logic [3:0] i_rrate,
  input  logic [3:0] i_sl,
  input  logic [9:0] i_eg_in,
  output logic       o_attack,
  output logic       o_step,
  output logic [4:0] o_rate,
  output logic       o_sum_up,
  output logic [1:0] o_state
);

  logic [1:0]        w_state_head;
  logic              w_kon_prev;
  eg_state_t         w_cur;
  eg_state_t         w_next;
  logic [1:0]        w_next_bits;
  logic [4:0]        w_sl_ext;
  logic [3:0]        w_base;
  logic [3:0]        w_rof;
  logic [6:0]        w_rsum;
  logic [RATE_W-1:0] w_rate;
  logic [3:0]        w_q;
  logic [3:0]        w_m;
  logic [14:0]       w_mask;
  logic [14:0]       w_cnt_shift;
  logic [2:0]        w_idx;
  logic              w_sum_up;
  logic              w_step;

  logic [14:0]       r_cnt;
  logic              r_attack;
  logic              r_step;
  logic [4:0]        r_rate;
  logic              r_sum_up;
  logic [1:0]        r_state;

  jtopl_eg_ring #(.W(2), .SLOTS(SLOTS), .RST_VAL(2'd3)) u_state_ring (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cen   (i_cen),
    .i_din   (w_next_bits),
    .o_head  (w_state_head)
  );

  jtopl_eg_ring #(.W(1), .SLOTS(SLOTS), .RST_VAL(1'b0)) u_kon_ring (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_cen   (i_cen),
    .i_din   (i_keyon),
    .o_head  (w_kon_prev)
  );

  // sl==15 maps to the very bottom of the range rather than 15/32 of it
  assign w_sl_ext    = (i_sl == 4'hF) ? 5'd31 : {1'b0, i_sl};
  assign w_next_bits = w_next;

  always_comb begin
    w_cur  = eg_state_t'(w_state_head);
    w_next = w_cur;
    if (i_keyon && !w_kon_prev) begin
`ifdef JTOPL_EG_FASTATT_EN
      w_next = (i_arate == 4'hF) ? EG_DECAY : EG_ATTACK;
`else
      w_next = EG_ATTACK;
`endif
    end else if (!i_keyon) begin
      w_next = EG_RELEASE;
    end else begin
      case (w_cur)
        EG_ATTACK:  if (i_eg_in == 10'd0) w_next = EG_DECAY;
        EG_DECAY:   if (i_eg_in[9:5] >= w_sl_ext) w_next = i_egtype ? EG_SUSTAIN : EG_RELEASE;
        EG_SUSTAIN: if (!i_egtype) w_next = EG_RELEASE;
        default:    w_next = w_cur;
      endcase
    end
  end

  always_comb begin
    case (w_next)
      EG_ATTACK:  w_base = i_arate;
      EG_DECAY:   w_base = i_drate;
      EG_SUSTAIN: w_base = 4'd0;
      default:    w_base = i_rrate;
    endcase
    w_rof  = i_ksr ? i_keycode : {2'b00, i_keycode[3:2]};
    w_rsum = {1'b0, w_base, 2'b00} + {3'b000, w_rof};
    if (w_base == 4'd0)
      w_rate = '0;
    else if (w_rsum > 7'd63)
      w_rate = 6'd63;
    else
      w_rate = w_rsum[5:0];
  end

  // Slow rates advance only when the low m counter bits are all zero
  always_comb begin
    w_q         = w_rate[5:2];
    w_m         = 4'd11 - w_q;
    w_mask      = ~(15'h7FFF << w_m);
    w_cnt_shift = r_cnt >> w_m;
    if (w_q >= 4'd12) begin
      w_sum_up = 1'b1;
      w_idx    = r_cnt[2:0];
    end else begin
      w_sum_up = (w_rate != '0) && ((r_cnt & w_mask) == 15'd0);
      w_idx    = w_cnt_shift[2:0];
    end
    w_step = (w_rate == '0) ? 1'b0 : step_bit(w_rate[1:0], w_idx);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_attack <= 1'b0;
      r_step   <= 1'b0;
      r_rate   <= '0;
      r_sum_up <= 1'b0;
      r_state  <= 2'd3;
    end else if (i_cen) begin
      if (i_zero) r_cnt <= r_cnt + 15'd1;
      r_attack <= (w_next == EG_ATTACK);
      r_step   <= w_step;
      r_rate   <= w_rate[5:1];
      r_sum_up <= w_sum_up;
      r_state  <= w_next_bits;
    end
  end

  assign o_attack = r_attack;
  assign o_step   = r_step;
  assign o_rate   = r_rate;
  assign o_sum_up = r_sum_up;
  assign o_state  = r_state;

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// Directed bench for jtopl_eg_ctrl; honours JTOPL_EG_FASTATT_EN in the
// fast-attack step.
module tb_jtopl_eg_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic       keyon = 1'b0;
  logic       egtype = 1'b1;
  logic       ksr = 1'b0;
  logic [3:0] keycode = '0;
  logic [3:0] arate = '0;
  logic [3:0] drate = '0;
  logic [3:0] rrate = '0;
  logic [3:0] sl = '0;
  logic [9:0] eg_in = '0;
  logic       attack;
  logic       step;
  logic [4:0] rate;
  logic       sum_up;
  logic [1:0] state;

  int          total = 0;
  int          bad = 0;
  int          tb_slot = 0;
  logic [14:0] tb_cnt = '0;
  logic        force_zero = 1'b0;
  logic        step_seq [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  jtopl_eg_ctrl #(.SLOTS(18)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_cen     (cen),
    .i_zero    (zero),
    .i_keyon   (keyon),
    .i_egtype  (egtype),
    .i_ksr     (ksr),
    .i_keycode (keycode),
    .i_arate   (arate),
    .i_drate   (drate),
    .i_rrate   (rrate),
    .i_sl      (sl),
    .i_eg_in   (eg_in),
    .o_attack  (attack),
    .o_step    (step),
    .o_rate    (rate),
    .o_sum_up  (sum_up),
    .o_state   (state)
  );

  task automatic check_sar(input string tag, input logic [1:0] st, input logic att, input logic [4:0] rt);
    total++;
    assert (state === st) else begin
      bad++; $error("FAIL %s state: observed=%0d expected=%0d", tag, state, st);
    end
    total++;
    assert (attack === att) else begin
      bad++; $error("FAIL %s attack: observed=%0d expected=%0d", tag, attack, att);
    end
    total++;
    assert (rate === rt) else begin
      bad++; $error("FAIL %s rate: observed=%0d expected=%0d", tag, rate, rt);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] st, input logic att,
                           input logic [4:0] rt, input logic su, input logic stp);
    check_sar(tag, st, att, rt);
    total++;
    assert (sum_up === su) else begin
      bad++; $error("FAIL %s sum_up: observed=%0d expected=%0d", tag, sum_up, su);
    end
    total++;
    assert (step === stp) else begin
      bad++; $error("FAIL %s step: observed=%0d expected=%0d", tag, step, stp);
    end
  endtask

  task automatic visit();
    zero = force_zero || (tb_slot == 0);
    cen  = 1'b1;
    @(posedge clk);
    #1;
    if (zero) tb_cnt = tb_cnt + 15'd1;
    tb_slot = (tb_slot == 17) ? 0 : tb_slot + 1;
  endtask

  task automatic idle_inputs();
    keyon = 1'b0; egtype = 1'b1; ksr = 1'b0; keycode = '0;
    arate = '0; drate = '0; rrate = '0; sl = '0; eg_in = '0;
  endtask

  task automatic run_to_slot(input int s);
    idle_inputs();
    while (tb_slot != s) visit();
  endtask

  // Slot 5 channel: arate=10, drate=6, rrate=3, keycode=8, ksr=0
  task automatic slot5(input logic kon, input logic [9:0] eg, input logic et, input logic [3:0] slv);
    run_to_slot(5);
    keyon = kon; eg_in = eg; egtype = et; sl = slv;
    arate = 4'd10; drate = 4'd6; rrate = 4'd3; keycode = 4'd8; ksr = 1'b0;
    visit();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with cen low
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 2'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      visit();
      check_out("reset_ring", 2'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    end

    // key-on slot 5: r=42, seen cnt 2 then 3
    slot5(1'b1, 10'h3FF, 1'b1, 4'd4);
    check_out("keyon_even", 2'd0, 1'b1, 5'd21, 1'b1, 1'b1);
    slot5(1'b1, 10'h3FF, 1'b1, 4'd4);
    check_out("keyon_odd", 2'd0, 1'b1, 5'd21, 1'b0, 1'b1);

    // attack -> decay -> sustain, then sustain released by egtype=0
    slot5(1'b1, 10'd0, 1'b1, 4'd4);
    check_out("att_to_dec", 2'd1, 1'b0, 5'd13, 1'b0, 1'b1);
    slot5(1'b1, 10'd127, 1'b1, 4'd4);
    check_out("dec_below_sl", 2'd1, 1'b0, 5'd13, 1'b0, 1'b1);
    slot5(1'b1, 10'd128, 1'b1, 4'd4);
    check_out("dec_to_sus", 2'd2, 1'b0, 5'd0, 1'b0, 1'b0);
    slot5(1'b1, 10'd128, 1'b0, 4'd4);
    check_out("sus_perc_rel", 2'd3, 1'b0, 5'd7, 1'b0, 1'b1);

    // key-off then key-on on consecutive visits, percussive decay
    slot5(1'b0, 10'd128, 1'b0, 4'd4);
    check_out("keyoff", 2'd3, 1'b0, 5'd7, 1'b0, 1'b1);
    slot5(1'b1, 10'd128, 1'b0, 4'd4);
    check_out("rekeyon", 2'd0, 1'b1, 5'd21, 1'b0, 1'b1);
    slot5(1'b1, 10'd0, 1'b0, 4'd4);
    check_out("perc_dec", 2'd1, 1'b0, 5'd13, 1'b0, 1'b1);
    slot5(1'b1, 10'd128, 1'b0, 4'd4);
    check_out("perc_rel", 2'd3, 1'b0, 5'd7, 1'b0, 1'b1);

    // sl=15 means level 31
    slot5(1'b0, 10'd0, 1'b1, 4'd15);
    check_out("sl15_off", 2'd3, 1'b0, 5'd7, 1'b0, 1'b1);
    slot5(1'b1, 10'h3FF, 1'b1, 4'd15);
    check_out("sl15_on", 2'd0, 1'b1, 5'd21, 1'b0, 1'b1);
    slot5(1'b1, 10'd0, 1'b1, 4'd15);
    check_out("sl15_dec", 2'd1, 1'b0, 5'd13, 1'b0, 1'b1);
    slot5(1'b1, 10'h3DF, 1'b1, 4'd15);
    check_out("sl15_hold", 2'd1, 1'b0, 5'd13, 1'b0, 1'b1);
    slot5(1'b1, 10'h3E0, 1'b1, 4'd15);
    check_out("sl15_sus", 2'd2, 1'b0, 5'd0, 1'b0, 1'b0);

    // reset mid-frame with cen high
    idle_inputs();
    visit();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_mid", 2'd3, 1'b0, 5'd0, 1'b0, 1'b0);
    rst_n   = 1'b1;
    tb_slot = 0;
    tb_cnt  = '0;

    // r=49 on slot 0 sees cnt 0..7
    for (int f = 0; f < 8; f++) begin
      run_to_slot(0);
      keyon = 1'b0; rrate = 4'd12; keycode = 4'd4; ksr = 1'b0;
      visit();
      check_out("step_r49", 2'd3, 1'b0, 5'd24, 1'b1, step_seq[f]);
      if (f == 3) begin
        cen = 1'b0; rrate = 4'd0; keyon = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_out("cen_hold", 2'd3, 1'b0, 5'd24, 1'b1, 1'b0);
      end
    end

    // zero on every visit to reach the wrap quickly; r=4 -> m=10, P0
    force_zero = 1'b1;
    idle_inputs();
    rrate = 4'd1;
    while (tb_cnt != 15'h7FFE) visit();
    visit();
    check_out("cnt_32766", 2'd3, 1'b0, 5'd2, 1'b0, 1'b0);
    visit();
    check_out("cnt_32767", 2'd3, 1'b0, 5'd2, 1'b0, 1'b0);
    visit();
    check_out("cnt_wrap0", 2'd3, 1'b0, 5'd2, 1'b1, 1'b1);
    visit();
    check_out("cnt_wrap1", 2'd3, 1'b0, 5'd2, 1'b0, 1'b1);
    force_zero = 1'b0;

    // key-on with arate=15
    run_to_slot(9);
    keyon = 1'b1; arate = 4'd15; drate = 4'd2; ksr = 1'b1; keycode = 4'd8; eg_in = 10'h3FF;
    visit();
`ifdef JTOPL_EG_FASTATT_EN
    check_sar("fastatt", 2'd1, 1'b0, 5'd8);
`else
    check_sar("att15", 2'd0, 1'b1, 5'h1F);
    run_to_slot(9);
    keyon = 1'b1; arate = 4'd15; drate = 4'd2; ksr = 1'b1; keycode = 4'd8; eg_in = 10'd5;
    visit();
    check_sar("att15_hold", 2'd0, 1'b1, 5'h1F);
    run_to_slot(9);
    keyon = 1'b1; arate = 4'd15; drate = 4'd2; ksr = 1'b1; keycode = 4'd8; eg_in = 10'd0;
    visit();
    check_sar("att15_dec", 2'd1, 1'b0, 5'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
